// File: rtl/tricolor_cmp_pwm_if.sv
// tricolor_cmp_pwm_if
// Groups the operand/brightness inputs and the LED/valid outputs of
// tricolor_cmp_pwm.
//   a, b      : WIDTH-bit unsigned operands
//   duty      : PWM_BITS brightness (0 = off, all-ones = fully on)
//   blink_en  : light only on alternate PWM periods
//   red/green/blue : one-hot committed compare result, PWM gated
//   valid     : a result has been committed since reset
// Modports: master drives operands/controls, slave drives LEDs/valid.
interface tricolor_cmp_pwm_if #(
   parameter int WIDTH    = 4,
   parameter int PWM_BITS = 4
);
   logic [WIDTH-1:0]    a;
   logic [WIDTH-1:0]    b;
   logic [PWM_BITS-1:0] duty;
   logic                blink_en;
   logic                red;
   logic                green;
   logic                blue;
   logic                valid;

   modport master (
      output a, b, duty, blink_en,
      input  red, green, blue, valid
   );

   modport slave (
      input  a, b, duty, blink_en,
      output red, green, blue, valid
   );
endinterface

// File: rtl/tricolor_cmp_pwm.sv
// tricolor_cmp_pwm
// Compares two unsigned operands and drives a one-hot RGB LED code
// (red: a>b, green: a==b, blue: a<b). A result is committed only after
// it has been stable for STABLE_CYCLES cycles; the LEDs are PWM dimmed
// and can optionally blink on alternate PWM periods.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : tricolor_cmp_pwm_if.slave (a, b, duty, blink_en in;
//         red, green, blue, valid out)
//
// state  | meaning
// -------+-----------------------------------------------------------
// EMPTY  | nothing committed since reset, valid low
// LOCKED | committed equals the current candidate
// SETTLE | candidate differs from committed, stability being counted
module tricolor_cmp_pwm #(
   parameter int WIDTH         = 4,
   parameter int PWM_BITS      = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic               clk,
   input  logic               rst,
   tricolor_cmp_pwm_if.slave  bus
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_SAT = CW'(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_CMT = CW'(STABLE_CYCLES - 1);
   localparam logic [PWM_BITS-1:0] PWM_MAX = '1;
   localparam bit SINGLE = (STABLE_CYCLES == 1);

   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      LOCKED = 2'd1,
      SETTLE = 2'd2
   } state_t;

   state_t              state, state_nxt;
   logic [WIDTH-1:0]    a_q, b_q;
   logic                cap_vld;
   logic [2:0]          cand, cand_q, committed;
   logic [CW-1:0]       cnt;
   logic                changed, differs, commit;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic                phase, wrap, pwm_on, gate;
   logic [2:0]          rgb_q;
   logic                valid_q;

   // {gt, eq, lt}: exactly one bit set for any operand pair
   always_comb begin
      cand = {(a_q > b_q), (a_q == b_q), (a_q < b_q)};
   end

   // cap_vld marks that a_q/b_q hold real operands rather than reset zeros,
   // so an operand pair equal to the reset value still sees the full latency.
   always_comb begin
      changed = (cand != cand_q);
      differs = (cand != committed) || (state == EMPTY);
      if (SINGLE) begin
         commit = cap_vld && differs;
      end else begin
         commit = cap_vld && differs && !changed && (cnt == CNT_CMT);
      end
   end

   always_comb begin
      wrap   = (pwm_cnt == PWM_MAX);
      pwm_on = (pwm_cnt < bus.duty) || (bus.duty == PWM_MAX);
      gate   = pwm_on && (!bus.blink_en || !phase);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY: begin
            if (commit) state_nxt = LOCKED;
         end
         LOCKED: begin
            if (!commit && (cand != committed)) state_nxt = SETTLE;
         end
         SETTLE: begin
            if (commit || (cand == committed)) state_nxt = LOCKED;
         end
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= EMPTY;
         a_q       <= '0;
         b_q       <= '0;
         cap_vld   <= 1'b0;
         cand_q    <= 3'b000;
         cnt       <= '0;
         committed <= 3'b000;
         pwm_cnt   <= '0;
         phase     <= 1'b0;
         rgb_q     <= 3'b000;
         valid_q   <= 1'b0;
      end else begin
         state   <= state_nxt;
         a_q     <= bus.a;
         b_q     <= bus.b;
         cap_vld <= 1'b1;
         cand_q  <= cap_vld ? cand : 3'b000;

         if (!cap_vld) begin
            cnt <= '0;
         end else if (changed) begin
            cnt <= CW'(1);
         end else if (cnt != CNT_SAT) begin
            cnt <= cnt + CW'(1);
         end

         if (commit) committed <= cand;

         pwm_cnt <= pwm_cnt + PWM_BITS'(1);
         if (wrap) phase <= ~phase;

         rgb_q   <= committed & {3{gate}};
         valid_q <= (state != EMPTY);
      end
   end

   assign bus.red   = rgb_q[2];
   assign bus.green = rgb_q[1];
   assign bus.blue  = rgb_q[0];
   assign bus.valid = valid_q;

endmodule

// File: tb/tb_tricolor_cmp_pwm.sv
module tb_tricolor_cmp_pwm;

   logic clk;
   logic rst;
   int   passed;
   int   total;
   int   ncyc;

   // expected {red, green, blue, valid}
   logic [3:0] sb[$];
   logic [3:0] e;
   logic [3:0] got;

   localparam logic [3:0] OFF   = 4'b0000;
   localparam logic [3:0] RED   = 4'b1001;
   localparam logic [3:0] GREEN = 4'b0101;
   localparam logic [3:0] BLUE  = 4'b0011;
   localparam logic [3:0] DARK  = 4'b0001;

   tricolor_cmp_pwm_if #(.WIDTH(4), .PWM_BITS(4)) bus ();

   tricolor_cmp_pwm #(.WIDTH(4), .PWM_BITS(4), .STABLE_CYCLES(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ncyc counts non-reset edges since the last reset edge, which is
   // what the free-running PWM counter follows.
   task automatic step();
      @(posedge clk);
      if (rst) ncyc = 0;
      else     ncyc = ncyc + 1;
      #1;
      got = {bus.red, bus.green, bus.blue, bus.valid};
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.a = 4'd3; bus.b = 4'd3; bus.duty = 4'd15; bus.blink_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         sb.push_back(OFF);
         step();
         e = sb.pop_front(); total++;
         if (got !== e) $display("FAIL reset_hold cyc=%0d got=%b exp=%b", i, got, e);
         else passed++;
      end
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         sb.push_back((k >= 5) ? GREEN : OFF);
         step();
         e = sb.pop_front(); total++;
         if (got !== e) $display("FAIL reset_latency k=%0d got=%b exp=%b", k, got, e);
         else passed++;
      end
   endtask

   task automatic test_sweep();
      logic [3:0] va [4] = '{4'd9, 4'd4, 4'd0, 4'd15};
      logic [3:0] vb [4] = '{4'd4, 4'd9, 4'd15, 4'd15};
      logic [3:0] vc [4] = '{RED, BLUE, BLUE, GREEN};
      logic [3:0] prev;
      prev = GREEN;
      for (int t = 0; t < 4; t++) begin
         bus.a = va[t]; bus.b = vb[t];
         for (int k = 0; k < 8; k++) begin
            sb.push_back((k >= 5) ? vc[t] : prev);
            step();
            e = sb.pop_front(); total++;
            if (got !== e) $display("FAIL sweep a=%0d b=%0d k=%0d got=%b exp=%b", va[t], vb[t], k, got, e);
            else passed++;
         end
         prev = vc[t];
      end
   endtask

   task automatic test_glitch();
      bus.a = 4'd7; bus.b = 4'd2;
      for (int k = 0; k < 13; k++) begin
         if (k == 3) begin bus.a = 4'd5; bus.b = 4'd5; end
         sb.push_back(GREEN);
         step();
         e = sb.pop_front(); total++;
         if (got !== e) $display("FAIL glitch3 k=%0d got=%b exp=%b", k, got, e);
         else passed++;
      end
      bus.a = 4'd7; bus.b = 4'd2;
      for (int k = 0; k < 13; k++) begin
         if (k == 4) begin bus.a = 4'd5; bus.b = 4'd5; end
         sb.push_back((k < 5) ? GREEN : (k <= 8) ? RED : GREEN);
         step();
         e = sb.pop_front(); total++;
         if (got !== e) $display("FAIL glitch4 k=%0d got=%b exp=%b", k, got, e);
         else passed++;
      end
   endtask

   task automatic test_pwm();
      bus.duty = 4'd4;
      for (int k = 0; k < 32; k++) begin
         sb.push_back(((ncyc % 16) < 4) ? GREEN : DARK);
         step();
         e = sb.pop_front(); total++;
         if (got !== e) $display("FAIL pwm_duty4 k=%0d got=%b exp=%b", k, got, e);
         else passed++;
      end
      bus.duty = 4'd0;
      for (int k = 0; k < 16; k++) begin
         sb.push_back(DARK);
         step();
         e = sb.pop_front(); total++;
         if (got !== e) $display("FAIL pwm_duty0 k=%0d got=%b exp=%b", k, got, e);
         else passed++;
      end
      bus.duty = 4'd15;
      sb.push_back(GREEN);
      step();
      e = sb.pop_front(); total++;
      if (got !== e) $display("FAIL pwm_full got=%b exp=%b", got, e);
      else passed++;
   endtask

   task automatic test_blink();
      bit found;
      bus.duty = 4'd15; bus.blink_en = 1'b1;
      for (int k = 0; k < 64; k++) begin
         sb.push_back((((ncyc / 16) % 2) == 0) ? GREEN : DARK);
         step();
         e = sb.pop_front(); total++;
         if (got !== e) $display("FAIL blink k=%0d got=%b exp=%b", k, got, e);
         else passed++;
      end
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         if ((((ncyc / 16) % 2) == 1) && ((ncyc % 16) == 4)) begin
            found = 1'b1;
         end else begin
            sb.push_back((((ncyc / 16) % 2) == 0) ? GREEN : DARK);
            step();
            e = sb.pop_front(); total++;
            if (got !== e) $display("FAIL blink_seek k=%0d got=%b exp=%b", k, got, e);
            else passed++;
         end
      end
      total++;
      if (!found) begin
         $display("FAIL blink_dark_window timeout got=%0d exp=%0d", 0, 1);
      end else begin
         if (got !== DARK) $display("FAIL blink_dark_before got=%b exp=%b", got, DARK);
         else passed++;
         bus.blink_en = 1'b0;
         sb.push_back(GREEN);
         step();
         e = sb.pop_front(); total++;
         if (got !== e) $display("FAIL blink_release got=%b exp=%b", got, e);
         else passed++;
      end
   endtask

   task automatic test_reset_settle();
      bus.a = 4'd7; bus.b = 4'd2;
      for (int k = 0; k < 3; k++) begin
         sb.push_back(GREEN);
         step();
         e = sb.pop_front(); total++;
         if (got !== e) $display("FAIL settle_pre k=%0d got=%b exp=%b", k, got, e);
         else passed++;
      end
      rst = 1'b1;
      sb.push_back(OFF);
      step();
      e = sb.pop_front(); total++;
      if (got !== e) $display("FAIL settle_reset got=%b exp=%b", got, e);
      else passed++;
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         sb.push_back((k >= 5) ? RED : OFF);
         step();
         e = sb.pop_front(); total++;
         if (got !== e) $display("FAIL settle_recommit k=%0d got=%b exp=%b", k, got, e);
         else passed++;
      end
   endtask

   initial begin
      passed = 0;
      total  = 0;
      ncyc   = 0;
      test_reset();
      test_sweep();
      test_glitch();
      test_pwm();
      test_blink();
      test_reset_settle();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
